// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and encodings for the memory bus arbiter slice.
// Imported by the interface, the round-robin picker and the arbiter top.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   // Only the load/store unit can write; fetch is read-only.
   function automatic logic is_write(input logic owner, input logic we);
      return (owner == OWN_DATA) && we;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus the memory port, bundled as one bus.
// master = the arbiter; slave = the requesters and memory around it.
interface mem_bus_arbiter_if
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);

   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_done;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_done;

   logic [DATA_W-1:0] rdata;
   logic              err;

   logic              mem_en;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mfc;

   logic              busy;

   modport master (
      input  f_req, f_addr,
      output f_gnt, f_done,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_done,
      output rdata, err,
      output mem_en, mem_rw, mem_addr, mem_wdata,
      input  mem_rdata, mfc,
      output busy
   );

   modport slave (
      output f_req, f_addr,
      input  f_gnt, f_done,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_done,
      input  rdata, err,
      input  mem_en, mem_rw, mem_addr, mem_wdata,
      output mem_rdata, mfc,
      input  busy
   );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
// Purely combinational; the caller owns the last-served register.
module rr_arb2
   import mem_bus_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         winner = (last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
      end else if (req1) begin
         winner = OWN_DATA;
      end else begin
         winner = OWN_FETCH;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the MAR/MDR memory port between instruction fetch and load/store.
// Optional MEM_TIMEOUT_EN aborts an ACCESS after TIMEOUT cycles without mfc.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input logic               clk,
   input logic               reset,
   mem_bus_arbiter_if.master bus
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_GRANT  = GRANT;
   localparam logic [1:0] ST_ACCESS = ACCESS;
   localparam logic [1:0] ST_DONE   = DONE;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT must be in 1..255");
   end

   logic [1:0]        state_reg, state_next;
   logic              owner_reg, owner_next;
   logic              last_owner_reg, last_owner_next;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] mar_reg, mar_next;
   logic [DATA_W-1:0] mdr_reg, mdr_next;

   logic arb_valid;
   logic arb_winner;
   logic timeout_hit;
   logic wr_access;

   rr_arb2 u_rr_arb2 (
      .req0   (bus.f_req),
      .req1   (bus.d_req),
      .last   (last_owner_reg),
      .valid  (arb_valid),
      .winner (arb_winner)
   );

   assign wr_access = is_write(owner_reg, we_reg);

`ifdef MEM_TIMEOUT_EN
   logic [7:0] tmo_cnt_reg, tmo_cnt_next;
   logic       err_reg;

   // The compare looks one count ahead so ACCESS lasts exactly TIMEOUT cycles.
   assign timeout_hit = (state_reg == ST_ACCESS) && !bus.mfc &&
                        ((tmo_cnt_reg + 8'd1) == 8'(TIMEOUT));

   always_comb begin
      tmo_cnt_next = tmo_cnt_reg;
      if (state_reg == ST_GRANT) begin
         tmo_cnt_next = 8'd0;
      end else if (state_reg == ST_ACCESS && !bus.mfc) begin
         tmo_cnt_next = tmo_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_reg <= 8'd0;
         err_reg     <= 1'b0;
      end else begin
         tmo_cnt_reg <= tmo_cnt_next;
         if (state_reg == ST_ACCESS) begin
            err_reg <= timeout_hit;
         end
      end
   end

   assign bus.err = (state_reg == ST_DONE) && err_reg;
`else
   assign timeout_hit = 1'b0;
   assign bus.err     = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      we_next         = we_reg;
      mar_next        = mar_reg;
      mdr_next        = mdr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (arb_valid) begin
               owner_next = arb_winner;
               state_next = ST_GRANT;
            end
         end
         ST_GRANT: begin
            last_owner_next = owner_reg;
            if (owner_reg == OWN_DATA) begin
               mar_next = bus.d_addr;
               we_next  = bus.d_we;
               if (bus.d_we) begin
                  mdr_next = bus.d_wdata;
               end
            end else begin
               mar_next = bus.f_addr;
               we_next  = 1'b0;
            end
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            // mfc takes priority over a timeout landing in the same cycle.
            if (bus.mfc) begin
               if (!wr_access) begin
                  mdr_next = bus.mem_rdata;
               end
               state_next = ST_DONE;
            end else if (timeout_hit) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= OWN_FETCH;
         last_owner_reg <= OWN_DATA;
         we_reg         <= 1'b0;
         mar_reg        <= '0;
         mdr_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         we_reg         <= we_next;
         mar_reg        <= mar_next;
         mdr_reg        <= mdr_next;
      end
   end

   assign bus.f_gnt     = (state_reg == ST_GRANT) && (owner_reg == OWN_FETCH);
   assign bus.d_gnt     = (state_reg == ST_GRANT) && (owner_reg == OWN_DATA);
   assign bus.f_done    = (state_reg == ST_DONE) && (owner_reg == OWN_FETCH);
   assign bus.d_done    = (state_reg == ST_DONE) && (owner_reg == OWN_DATA);
   assign bus.busy      = (state_reg != ST_IDLE);

   assign bus.mem_en    = (state_reg == ST_ACCESS);
   assign bus.mem_rw    = (state_reg == ST_ACCESS && !wr_access) ? MEM_READ : MEM_WRITE;
   assign bus.mem_addr  = mar_reg;
   assign bus.mem_wdata = (state_reg == ST_ACCESS && wr_access) ? mdr_reg : '0;
   assign bus.rdata     = mdr_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed table, corner sequences,
// and randomized rounds against a transaction-level arbitration/memory model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
`ifdef MEM_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 15;
`endif
   localparam int NEVER = 100000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // environment memory (what the memory device holds) and reference memory
   logic [15:0] env_mem [256];
   logic [15:0] ref_mem [256];
   int  mem_lat   = 0;
   bit  mem_auto  = 1'b1;
   bit  mfc_force = 1'b0;
   int  acc_cnt   = 0;

   int n_cmp = 0;
   int n_err = 0;
   int n_txn = 0;
   logic last_served;

   // memory responder: raises mfc mem_lat cycles into each enabled access
   initial begin
      bus.mfc       = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!mem_auto) begin
            bus.mfc = mfc_force;
         end else if (bus.mem_en) begin
            if (acc_cnt == mem_lat) begin
               bus.mfc       = 1'b1;
               bus.mem_rdata = env_mem[bus.mem_addr];
               if (bus.mem_rw == MEM_WRITE) env_mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
               bus.mfc = 1'b0;
            end
            acc_cnt++;
         end else begin
            bus.mfc = 1'b0;
            acc_cnt = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic init_mems();
      for (int a = 0; a < 256; a++) begin
         env_mem[a] = {8'hC3, 8'(a)};
         ref_mem[a] = {8'hC3, 8'(a)};
      end
      env_mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
      env_mem[8'h21] = 16'h5A5A; ref_mem[8'h21] = 16'h5A5A;
   endtask

   task automatic do_reset();
      bus.f_req = 1'b0;
      bus.d_req = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   // One complete access: wait grant, check ACCESS, wait done, check result.
   task automatic serve(input logic is_f, input logic [7:0] addr, input logic wr,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input int lat);
      int n;
      mem_lat = lat;
      n = 0;
      while (!(bus.f_gnt || bus.d_gnt) && n < 10) begin tick(); n++; end
      chk("gnt_seen", 32'(n < 10), 1);
      chk("gnt_owner", {bus.f_gnt, bus.d_gnt}, is_f ? 2'b10 : 2'b01);
      chk("gnt_mem_idle", bus.mem_en, 1'b0);
      tick();
      chk("acc_mem_en", bus.mem_en, 1'b1);
      chk("acc_busy", bus.busy, 1'b1);
      chk("acc_rw", bus.mem_rw, wr ? MEM_WRITE : MEM_READ);
      chk("acc_addr", bus.mem_addr, addr);
      if (wr) chk("acc_wdata", bus.mem_wdata, wd);
      n = 1;
      while (!(bus.f_done || bus.d_done) && n < 300) begin tick(); n++; end
      chk("done_seen", 32'(n < 300), 1);
      chk("done_owner", {bus.f_done, bus.d_done}, is_f ? 2'b10 : 2'b01);
      chk("done_latency", n, lat + 2);
      chk("done_rdata", bus.rdata, exp_rd);
      chk("done_err", bus.err, 1'b0);
      if (is_f) bus.f_req = 1'b0;
      else      bus.d_req = 1'b0;
      n_txn++;
      $display("txn %0d: %s %s addr=0x%02h rdata=0x%04h lat=%0d", n_txn,
               is_f ? "fetch" : "data ", wr ? "wr" : "rd", addr, bus.rdata, lat);
   endtask

   // reference step: memory semantics and round-robin bookkeeping
   task automatic model_serve(input logic is_f, input logic [7:0] fa, input logic [7:0] da,
                              input logic we, input logic [15:0] wd);
      logic [7:0]  addr;
      logic        wr;
      logic [15:0] exp;
      addr = is_f ? fa : da;
      wr   = !is_f && we;
      exp  = wr ? wd : ref_mem[addr];
      if (wr) ref_mem[addr] = wd;
      serve(is_f, addr, wr, wd, exp, $urandom_range(0, 3));
      last_served = is_f ? OWN_FETCH : OWN_DATA;
   endtask

   typedef struct {
      logic        f_req;
      logic        d_req;
      logic [7:0]  f_addr;
      logic [7:0]  d_addr;
      logic        d_we;
      logic [15:0] d_wdata;
      int          lat;
      logic        first_f;
      logic [15:0] rd_first;
      logic [15:0] rd_second;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int         n;
      bit         saw_done;
      logic       fr, dr, we, first_f;
      logic [7:0] fa, da;
      logic [15:0] wd;

      vecs[0] = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b1, 16'h1234, 3, 1'b1, 16'hBEEF, 16'h1234};
      vecs[1] = '{1'b1, 1'b1, 8'h21, 8'h20, 1'b0, 16'h0000, 0, 1'b1, 16'h5A5A, 16'h1234};
      vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h21, 1'b1, 16'h0F0F, 1, 1'b0, 16'h0F0F, 16'h0000};
      vecs[3] = '{1'b1, 1'b0, 8'h21, 8'h00, 1'b0, 16'h0000, 2, 1'b1, 16'h0F0F, 16'h0000};
      vecs[4] = '{1'b1, 1'b1, 8'h20, 8'h21, 1'b0, 16'h0000, 1, 1'b0, 16'h0F0F, 16'h1234};

      bus.f_req = 1'b0; bus.f_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      init_mems();
      do_reset();

      chk("rst_gnt", {bus.f_gnt, bus.d_gnt}, 2'b00);
      chk("rst_done", {bus.f_done, bus.d_done}, 2'b00);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_mem_en", {bus.mem_en, bus.mem_rw}, 2'b00);
      chk("rst_mem_addr", bus.mem_addr, 8'h00);
      chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
      chk("rst_rdata", bus.rdata, 16'h0000);
      chk("rst_err", bus.err, 1'b0);

      // directed table; rows 0-1 give grant order fetch, data, fetch, data
      for (int i = 0; i < 5; i++) begin
         bus.f_req   = vecs[i].f_req;   bus.f_addr  = vecs[i].f_addr;
         bus.d_req   = vecs[i].d_req;   bus.d_addr  = vecs[i].d_addr;
         bus.d_we    = vecs[i].d_we;    bus.d_wdata = vecs[i].d_wdata;
         first_f = vecs[i].first_f;
         serve(first_f, first_f ? vecs[i].f_addr : vecs[i].d_addr,
               !first_f && vecs[i].d_we, vecs[i].d_wdata, vecs[i].rd_first, vecs[i].lat);
         if (vecs[i].f_req && vecs[i].d_req)
            serve(!first_f, first_f ? vecs[i].d_addr : vecs[i].f_addr,
                  first_f && vecs[i].d_we, vecs[i].d_wdata, vecs[i].rd_second, vecs[i].lat);
         tick();
      end

      // reset in the middle of an access: no done, port released at once
      mem_lat = NEVER;
      bus.f_addr = 8'h40; bus.f_req = 1'b1;
      n = 0;
      while (!bus.mem_en && n < 10) begin tick(); n++; end
      chk("rstacc_reached", bus.mem_en, 1'b1);
      tick();
      reset = 1'b1; bus.f_req = 1'b0;
      tick();
      chk("rstacc_mem_en", bus.mem_en, 1'b0);
      chk("rstacc_busy", bus.busy, 1'b0);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (bus.f_done || bus.d_done) saw_done = 1'b1;
      end
      chk("rstacc_no_done", saw_done, 1'b0);
      bus.f_addr = 8'h10; bus.f_req = 1'b1;
      serve(1'b1, 8'h10, 1'b0, 16'h0, 16'hBEEF, 1);
      tick();

      // mfc pulsed while idle must be ignored
      mem_auto = 1'b0; mfc_force = 1'b1;
      tick(); tick(); tick();
      chk("idle_mfc_busy", bus.busy, 1'b0);
      chk("idle_mfc_done", {bus.f_done, bus.d_done}, 2'b00);
      chk("idle_mfc_rdata", bus.rdata, 16'hBEEF);
      mfc_force = 1'b0;
      tick();
      mem_auto = 1'b1;
      tick();
      // mfc in the first ACCESS cycle completes on the next cycle
      bus.f_addr = 8'h21; bus.f_req = 1'b1;
      serve(1'b1, 8'h21, 1'b0, 16'h0, 16'h0F0F, 0);
      tick();

`ifdef MEM_TIMEOUT_EN
      // no mfc at all: abort after TIMEOUT ACCESS cycles, MDR untouched
      mem_lat = NEVER;
      bus.f_addr = 8'h30; bus.f_req = 1'b1;
      n = 0;
      while (!bus.f_gnt && n < 10) begin tick(); n++; end
      chk("tmo_gnt", bus.f_gnt, 1'b1);
      tick();
      n = 0;
      while (bus.mem_en && n < 50) begin n++; tick(); end
      chk("tmo_mem_en_cycles", n, 4);
      chk("tmo_done", bus.f_done, 1'b1);
      chk("tmo_err", bus.err, 1'b1);
      chk("tmo_rdata", bus.rdata, 16'h0F0F);
      bus.f_req = 1'b0;
      n_txn++;
      $display("txn %0d: fetch rd addr=0x30 aborted err=%0b", n_txn, bus.err);
      tick();
      chk("tmo_err_cleared", bus.err, 1'b0);
`endif

      // randomized rounds against the reference model
      init_mems();
      do_reset();
      last_served = OWN_DATA;
      for (int r = 0; r < 40; r++) begin
         fr = 1'($urandom_range(0, 1));
         dr = 1'($urandom_range(0, 1));
         if (!fr && !dr) fr = 1'b1;
         fa = 8'($urandom_range(0, 255));
         da = 8'($urandom_range(0, 255));
         we = 1'($urandom_range(0, 1));
         wd = 16'($urandom);
         bus.f_req = fr; bus.f_addr = fa;
         bus.d_req = dr; bus.d_addr = da; bus.d_we = we; bus.d_wdata = wd;
         first_f = fr && (!dr || last_served == OWN_DATA);
         model_serve(first_f, fa, da, we, wd);
         if (fr && dr) model_serve(!first_f, fa, da, we, wd);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the CPU's single memory port (MAR/MDR/MEM) between two requesters: the instruction-fetch FSM (read-only) and the execute-stage load/store unit (read/write).
Arbitrates with round-robin priority and latches address and write data into internal MAR/MDR registers.
Drives the memory enable and direction controls, waits for the memory-function-complete (mfc) handshake, then returns read data and a done pulse to the winning requester.

Parameters:
ADDR_W, 8, address width of MAR and both requester address buses
DATA_W, 16, data width of MDR, memory and requester data buses
TIMEOUT, 15, max ACCESS cycles before abort (used only with MEM_TIMEOUT_EN); range 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
f_req  in  1  fetch request, level
f_addr  in  ADDR_W  fetch address (PC value)
f_gnt  out  1  one-cycle pulse: fetch request accepted
f_done  out  1  one-cycle pulse: fetch access complete, rdata valid
d_req  in  1  data request, level
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  load/store address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_done  out  1  one-cycle pulse: data access complete
rdata  out  DATA_W  MDR contents; shared by both requesters
err  out  1  access aborted; valid with *_done
mem_en  out  1  memory enable
mem_rw  out  1  1 = read, 0 = write
mem_addr  out  ADDR_W  MAR contents
mem_wdata  out  DATA_W  MDR contents during write
mem_rdata  in  DATA_W  memory read data
mfc  in  1  memory function complete, active-high, sampled only in ACCESS
busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE: sample f_req/d_req. Any request -> GRANT.
  - GRANT: latch owner and MAR. For a store, latch d_wdata into MDR. Pulse owner's gnt -> ACCESS.
  - ACCESS: mem_en=1, mem_rw=~(owner==DATA && we). On mfc=1: for reads, MDR <= mem_rdata -> DONE.
  - DONE: pulse owner's done -> IDLE.
- Arbitration:
  - Only one requester in IDLE: that requester wins.
  - Both requesting: the requester not served last wins.
  - last_owner updates in GRANT.
- Latency:
  - req high in IDLE at cycle 0 -> gnt at cycle 1 -> mem_en from cycle 2.
  - mfc first sampled high at cycle k (k≥2) -> done at cycle k+1 -> IDLE at k+2.
  - Minimum req-to-done is 3 cycles.
- Requester contract:
  - Hold req, addr, we and wdata stable until gnt.
  - Deassert req in the cycle done is seen.
  - req still high in IDLE is a new request.
- rdata holds the last MDR value until the next capture.
- Store: rdata = stored value after done.
- mfc outside ACCESS is ignored. mfc must drop before the next ACCESS; a level mfc still high at entry completes immediately (legal).
- Reset: all outputs 0, MAR=0, MDR=0, state=IDLE, last_owner=DATA (fetch wins the first tie). Reset during ACCESS drops mem_en at the next edge, and no done is issued.
- Simultaneous reset and mfc: reset wins.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without mfc. When it reaches TIMEOUT -> DONE with err=1 and MDR unchanged. err is 0 on every normal completion.
- Undefined: ACCESS waits indefinitely, no counter is synthesized, err is tied 0.

Decomposition:
- Package mem_bus_pkg:
  - state enum (IDLE, GRANT, ACCESS, DONE)
  - owner encoding OWN_FETCH=0, OWN_DATA=1
  - rw constants MEM_READ=1, MEM_WRITE=0
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req0, req1, last) -> winner.

Test Plan:
- Reset pulse, then f_req=1 with f_addr=0x10; mfc high 3 cycles after mem_en with mem_rdata=0xBEEF:
  - f_gnt at cycle 1, mem_en=1 and mem_rw=1 with mem_addr=0x10
  - f_done once, with rdata=0xBEEF and err=0
- Store d_we=1, d_addr=0x20, d_wdata=0x1234 -> mem_rw=0, mem_addr=0x20, mem_wdata=0x1234; d_done after mfc.
- f_req and d_req asserted together, twice in succession after reset:
  - grant order fetch, data, fetch, data
  - no overlapping mem_en windows
- reset asserted while in ACCESS -> mem_en=0 and busy=0 the next cycle; no done pulse; a later fetch completes normally.
- mfc pulsed while IDLE -> no state change; mfc high in first ACCESS cycle -> done next cycle.
- With MEM_TIMEOUT_EN and TIMEOUT=4, mfc never asserted:
  - mem_en high exactly 4 cycles, then f_done=1 and err=1
  - rdata unchanged from the previous value
